branch_predict_unit: RTL and testbench

//  Parametrised successor to the ID-stage branch comparator. Keeps a PC-indexed table of

---
 rtl/branch_predict_unit_pkg.sv | 29 ++
 rtl/branch_predict_unit_cond_eval.sv | 73 +++++++
 rtl/branch_predict_unit.sv | 118 +++++++++++
 tb/tb_branch_predict_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
// ---------------------------------------------------------------------------
// branch_predict_unit_pkg
// Shared definitions for the branch prediction unit:
//   - MIPS opcode / REGIMM rt selector constants for the six conditional
//     branches resolved in ID
//   - 2-bit saturating counter encodings (strongly/weakly not-taken/taken)
// ---------------------------------------------------------------------------
package branch_predict_unit_pkg;

    // Primary opcode field values
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    // rt selectors under OP_REGIMM
    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;

    // Counter encodings for CNT_W = 2
    typedef enum logic [1:0] {
        SN = 2'b00,
        WN = 2'b01,
        WT = 2'b10,
        ST = 2'b11
    } cnt2_e;

endpackage

// File: rtl/branch_predict_unit_cond_eval.sv
// ---------------------------------------------------------------------------
// branch_cond_eval
// Purely combinational decode and resolution of the six conditional branches
// (beq, bne, bgez, bgtz, blez, bltz).
// Ports:
//   op        in   6       opcode field
//   rt        in   5       rt field, selects bgez/bltz under REGIMM
//   rd1       in   DATA_W  forwarded rs value
//   rd2       in   DATA_W  forwarded rt value
//   is_branch out  1       instruction is one of the six branches
//   taken     out  1       branch condition holds; 0 when not a branch
// ---------------------------------------------------------------------------
module branch_cond_eval
    import branch_predict_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [5:0]        op,
    input  logic [4:0]        rt,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    output logic              is_branch,
    output logic              taken
);

    // Signed compares against zero reduce to the sign bit and a zero test
    logic rd1_neg;
    logic rd1_zero;
    logic ops_equal;

    assign rd1_neg   = rd1[DATA_W-1];
    assign rd1_zero  = (rd1 == '0);
    assign ops_equal = (rd1 == rd2);

    // Decode and resolve; anything not listed (including other REGIMM rt
    // values) is not a branch and reports not-taken
    always_comb begin
        is_branch = 1'b0;
        taken     = 1'b0;
        unique case (op)
            OP_BEQ: begin
                is_branch = 1'b1;
                taken     = ops_equal;
            end
            OP_BNE: begin
                is_branch = 1'b1;
                taken     = ~ops_equal;
            end
            OP_BLEZ: begin
                is_branch = 1'b1;
                taken     = rd1_neg | rd1_zero;
            end
            OP_BGTZ: begin
                is_branch = 1'b1;
                taken     = ~rd1_neg & ~rd1_zero;
            end
            OP_REGIMM: begin
                if (rt == RT_BGEZ) begin
                    is_branch = 1'b1;
                    taken     = ~rd1_neg;
                end else if (rt == RT_BLTZ) begin
                    is_branch = 1'b1;
                    taken     = rd1_neg;
                end
            end
            default: begin
                is_branch = 1'b0;
                taken     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
// PC-indexed table of saturating counters predicting taken/not-taken for IF,
// plus ID-stage branch resolution, mispredict detection, table training and
// a saturating mispredict statistic.
// Ports:
//   clk            in   1       rising-edge clock
//   reset          in   1       synchronous, active-high
//   if_pc          in   32      IF lookup address
//   if_pred_taken  out  1       MSB of the indexed counter (combinational)
//   id_valid       in   1       ID holds a real instruction
//   id_stall       in   1       ID frozen; suppresses training and counting
//   id_pc          in   32      ID training address
//   id_op          in   6       opcode field
//   id_rt          in   5       rt field
//   id_rd1         in   DATA_W  forwarded rs value
//   id_rd2         in   DATA_W  forwarded rt value
//   id_pred_taken  in   1       prediction carried in the IF/ID register
//   id_is_branch   out  1       ID holds a conditional branch
//   id_taken       out  1       resolved outcome
//   id_mispredict  out  1       valid branch whose outcome differs from prediction
//   mispredict_cnt out  STAT_W  saturating mispredict count
// ---------------------------------------------------------------------------
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 2,
    parameter int INIT_CNT  = 1,
    parameter int STAT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       if_pc,
    output logic              if_pred_taken,
    input  logic              id_valid,
    input  logic              id_stall,
    input  logic [31:0]       id_pc,
    input  logic [5:0]        id_op,
    input  logic [4:0]        id_rt,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic              id_pred_taken,
    output logic              id_is_branch,
    output logic              id_taken,
    output logic              id_mispredict,
    output logic [STAT_W-1:0] mispredict_cnt
);

    localparam int                IDX_W    = $clog2(BHT_DEPTH);
    localparam logic [CNT_W-1:0]  INIT_VAL = CNT_W'(INIT_CNT);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [CNT_W-1:0] bht [BHT_DEPTH];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] id_idx;
    logic             upd;

    // Word-aligned PCs; upper bits and byte offset do not take part in
    // indexing, so distinct branches may alias onto one entry
    assign if_idx = if_pc[IDX_W+1:2];
    assign id_idx = id_pc[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0],
                              id_pc[31:IDX_W+2], id_pc[1:0]};

    branch_cond_eval #(
        .DATA_W (DATA_W)
    ) u_cond_eval (
        .op        (id_op),
        .rt        (id_rt),
        .rd1       (id_rd1),
        .rd2       (id_rd2),
        .is_branch (id_is_branch),
        .taken     (id_taken)
    );

    // Asynchronous table read, no bypass of a same-cycle write
    assign if_pred_taken = bht[if_idx][CNT_W-1];

    assign id_mispredict = id_valid & id_is_branch & (id_taken != id_pred_taken);

    // A stalled branch is held in ID, so gating on ~id_stall makes it train
    // and count exactly once, on the cycle it leaves ID
    assign upd = id_valid & ~id_stall & id_is_branch;

    // Counter table: reset has priority over training
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= INIT_VAL;
            end
        end else if (upd) begin
            if (id_taken) begin
                if (bht[id_idx] != CNT_MAX) begin
                    bht[id_idx] <= bht[id_idx] + 1'b1;
                end
            end else begin
                if (bht[id_idx] != '0) begin
                    bht[id_idx] <= bht[id_idx] - 1'b1;
                end
            end
        end
    end

    // Saturating mispredict statistic
    always_ff @(posedge clk) begin
        if (reset) begin
            mispredict_cnt <= '0;
        end else if (upd && id_mispredict && (mispredict_cnt != STAT_MAX)) begin
            mispredict_cnt <= mispredict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_unit
// Directed self-checking bench for branch_predict_unit with default
// parameters (64 entries, 2-bit counters initialised to weakly not-taken).
// ---------------------------------------------------------------------------
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        id_valid;
    logic        id_stall;
    logic [31:0] id_pc;
    logic [5:0]  id_op;
    logic [4:0]  id_rt;
    logic [31:0] id_rd1;
    logic [31:0] id_rd2;
    logic        id_pred_taken;
    logic        id_is_branch;
    logic        id_taken;
    logic        id_mispredict;
    logic [15:0] mispredict_cnt;

    int errors = 0;
    int checks = 0;

    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101;
    localparam logic [5:0] BLEZ = 6'b000110;
    localparam logic [5:0] BGTZ = 6'b000111;
    localparam logic [5:0] RIMM = 6'b000001;

    branch_predict_unit dut (
        .clk            (clk),
        .reset          (reset),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .id_valid       (id_valid),
        .id_stall       (id_stall),
        .id_pc          (id_pc),
        .id_op          (id_op),
        .id_rt          (id_rt),
        .id_rd1         (id_rd1),
        .id_rd2         (id_rd2),
        .id_pred_taken  (id_pred_taken),
        .id_is_branch   (id_is_branch),
        .id_taken       (id_taken),
        .id_mispredict  (id_mispredict),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    // Counts one comparison and reports it if it differs
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives every ID input, then lets combinational outputs settle
    task automatic applyStimulus(input logic valid, input logic stall, input logic [31:0] pc,
                                 input logic [5:0] op, input logic [4:0] rt,
                                 input logic [31:0] rd1, input logic [31:0] rd2,
                                 input logic pred);
        id_valid      = valid;
        id_stall      = stall;
        id_pc         = pc;
        id_op         = op;
        id_rt         = rt;
        id_rd1        = rd1;
        id_rd2        = rd2;
        id_pred_taken = pred;
        #1;
    endtask

    // Advances one clock edge and moves away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [31:0] pc, input string tag, input logic exp);
        if_pc = pc;
        #1;
        checkOutput(tag, 32'(if_pred_taken), 32'(exp));
    endtask

    initial begin
        reset = 1'b1;
        if_pc = 32'h0;
        applyStimulus(1'b0, 1'b0, 32'h0, 6'h0, 5'h0, 32'h0, 32'h0, 1'b0);
        step();
        reset = 1'b0;
        #1;

        // 1: reset state
        peek(32'h0000_0000, "rst_pred_idx0", 1'b0);
        peek(32'h0000_00FC, "rst_pred_idx63", 1'b0);
        peek(32'h0000_3000, "rst_pred_3000", 1'b0);
        checkOutput("rst_cnt", 32'(mispredict_cnt), 32'd0);

        // 2: beq taken while predicted not-taken
        applyStimulus(1'b1, 1'b0, 32'h3000, BEQ, 5'h0, 32'd5, 32'd5, 1'b0);
        checkOutput("beq_is_branch", 32'(id_is_branch), 32'd1);
        checkOutput("beq_taken", 32'(id_taken), 32'd1);
        checkOutput("beq_mispredict", 32'(id_mispredict), 32'd1);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 6'h0, 5'h0, 32'h0, 32'h0, 1'b0);
        peek(32'h0000_3000, "beq_trained_pred", 1'b1);
        checkOutput("beq_cnt", 32'(mispredict_cnt), 32'd1);

        // 3: condition resolution, no clock edges
        applyStimulus(1'b0, 1'b0, 32'h0, RIMM, 5'b00000, 32'h8000_0000, 32'h0, 1'b0);
        checkOutput("bltz_neg_taken", 32'(id_taken), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, BLEZ, 5'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("blez_zero_taken", 32'(id_taken), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, BGTZ, 5'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("bgtz_zero_taken", 32'(id_taken), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, RIMM, 5'b00001, 32'h0, 32'h0, 1'b0);
        checkOutput("bgez_zero_taken", 32'(id_taken), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, BNE, 5'h0, 32'd3, 32'd4, 1'b0);
        checkOutput("bne_diff_taken", 32'(id_taken), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, BGTZ, 5'h0, 32'h7FFF_FFFF, 32'h0, 1'b0);
        checkOutput("bgtz_pos_taken", 32'(id_taken), 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h0, RIMM, 5'b00010, 32'h8000_0000, 32'h0, 1'b1);
        checkOutput("rimm_other_is_branch", 32'(id_is_branch), 32'd0);
        checkOutput("rimm_other_taken", 32'(id_taken), 32'd0);
        checkOutput("rimm_other_mispredict", 32'(id_mispredict), 32'd0);

        // 4: saturation on idx 3 (pc 0xC), counter 1 -> 2,3,3,3,3
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h000C, BEQ, 5'h0, 32'd9, 32'd9, 1'b1);
            step();
            peek(32'h0000_000C, $sformatf("sat_taken_%0d", i), 1'b1);
        end
        checkOutput("sat_cnt_no_mispredict", 32'(mispredict_cnt), 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h000C, BNE, 5'h0, 32'd9, 32'd9, 1'b1);
        step();
        peek(32'h0000_000C, "sat_nt_pred_stays", 1'b1);
        checkOutput("sat_nt_cnt", 32'(mispredict_cnt), 32'd2);
        applyStimulus(1'b1, 1'b0, 32'h000C, BNE, 5'h0, 32'd9, 32'd9, 1'b1);
        step();
        peek(32'h0000_000C, "sat_nt2_pred_drops", 1'b0);
        peek(32'h0000_100C, "alias_idx3_pred", 1'b0);
        checkOutput("sat_nt2_cnt", 32'(mispredict_cnt), 32'd3);

        // 5: stalled mispredicting bne at pc 0x40 (idx 16)
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h0040, BNE, 5'h0, 32'd1, 32'd2, 1'b0);
            checkOutput($sformatf("stall_mispredict_%0d", i), 32'(id_mispredict), 32'd1);
            step();
            checkOutput($sformatf("stall_cnt_hold_%0d", i), 32'(mispredict_cnt), 32'd3);
            peek(32'h0000_0040, $sformatf("stall_pred_hold_%0d", i), 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 32'h0040, BNE, 5'h0, 32'd1, 32'd2, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 6'h0, 5'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("release_cnt", 32'(mispredict_cnt), 32'd4);
        peek(32'h0000_0040, "release_pred", 1'b1);
        step();
        checkOutput("release_cnt_hold", 32'(mispredict_cnt), 32'd4);
        // counter must be 2 (single step): one not-taken takes it to 1
        applyStimulus(1'b1, 1'b0, 32'h0040, BEQ, 5'h0, 32'd1, 32'd2, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 6'h0, 5'h0, 32'h0, 32'h0, 1'b0);
        peek(32'h0000_0040, "single_step_pred", 1'b0);
        checkOutput("single_step_cnt", 32'(mispredict_cnt), 32'd5);

        // 6: same-cycle read/write on idx 7 (pc 0x1C)
        applyStimulus(1'b1, 1'b0, 32'h001C, BEQ, 5'h0, 32'd4, 32'd4, 1'b0);
        peek(32'h0000_001C, "rw_same_cycle_old", 1'b0);
        step();
        peek(32'h0000_001C, "rw_after_edge_new", 1'b1);
        checkOutput("rw_cnt", 32'(mispredict_cnt), 32'd6);
        // reset coincident with a taken update
        applyStimulus(1'b1, 1'b0, 32'h001C, BEQ, 5'h0, 32'd4, 32'd4, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 6'h0, 5'h0, 32'h0, 32'h0, 1'b0);
        peek(32'h0000_001C, "rst_wins_idx7", 1'b0);
        peek(32'h0000_3000, "rst_wins_idx0", 1'b0);
        checkOutput("rst_wins_cnt", 32'(mispredict_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
